// File: rtl/imm_decode_stage.sv
// RV32I immediate decode stage with a registered two-entry output buffer.
// A main register feeds the outputs and a skid register absorbs one extra
// entry, so in_ready comes straight from a flop and never from out_ready.
module imm_decode_stage #(
    parameter int unsigned DATAWIDTH = 32,
    parameter int unsigned TAGWIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          instr,
    input  logic [TAGWIDTH-1:0]  in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATAWIDTH-1:0] imm,
    output logic [2:0]           fmt,
    output logic                 illegal,
    output logic [TAGWIDTH-1:0]  out_tag
);

    localparam logic [2:0] FmtNone = 3'd0;
    localparam logic [2:0] FmtI    = 3'd1;
    localparam logic [2:0] FmtS    = 3'd2;
    localparam logic [2:0] FmtB    = 3'd3;
    localparam logic [2:0] FmtU    = 3'd4;
    localparam logic [2:0] FmtJ    = 3'd5;

    // Combinational decode of the incoming instruction
    logic [2:0]           dec_fmt;
    logic                 dec_illegal;
    logic signed [31:0]   dec_imm32;
    logic [DATAWIDTH-1:0] dec_imm;

    // Buffer state
    logic                 main_valid_q, main_valid_d;
    logic [DATAWIDTH-1:0] main_imm_q, main_imm_d;
    logic [2:0]           main_fmt_q, main_fmt_d;
    logic                 main_illegal_q, main_illegal_d;
    logic [TAGWIDTH-1:0]  main_tag_q, main_tag_d;

    logic                 skid_valid_q, skid_valid_d;
    logic [DATAWIDTH-1:0] skid_imm_q, skid_imm_d;
    logic [2:0]           skid_fmt_q, skid_fmt_d;
    logic                 skid_illegal_q, skid_illegal_d;
    logic [TAGWIDTH-1:0]  skid_tag_q, skid_tag_d;

    logic in_fire;
    logic main_free;

    // Select format from the opcode and assemble the 32-bit signed immediate
    always_comb begin
        dec_fmt     = FmtNone;
        dec_illegal = 1'b0;
        dec_imm32   = '0;
        case (instr[6:0])
            7'b0000011, 7'b0010011, 7'b1100111: begin
                dec_fmt   = FmtI;
                dec_imm32 = {{20{instr[31]}}, instr[31:20]};
            end
            7'b0100011: begin
                dec_fmt   = FmtS;
                dec_imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            7'b1100011: begin
                dec_fmt   = FmtB;
                dec_imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                             instr[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                dec_fmt   = FmtU;
                dec_imm32 = {instr[31:12], 12'b0};
            end
            7'b1101111: begin
                dec_fmt   = FmtJ;
                dec_imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                             instr[30:21], 1'b0};
            end
            7'b0110011: begin
                dec_fmt = FmtNone;
            end
            default: begin
                dec_illegal = 1'b1;
            end
        endcase
        // Signed cast sign-extends from instr[31]; U-type included
        dec_imm = DATAWIDTH'(dec_imm32);
    end

    // Next-state for main and skid entries; flush overrides any transfer
    always_comb begin
        main_valid_d   = main_valid_q;
        main_imm_d     = main_imm_q;
        main_fmt_d     = main_fmt_q;
        main_illegal_d = main_illegal_q;
        main_tag_d     = main_tag_q;
        skid_valid_d   = skid_valid_q;
        skid_imm_d     = skid_imm_q;
        skid_fmt_d     = skid_fmt_q;
        skid_illegal_d = skid_illegal_q;
        skid_tag_d     = skid_tag_q;

        in_fire   = in_valid && !skid_valid_q;
        main_free = !main_valid_q || out_ready;

        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (main_free) begin
            if (skid_valid_q) begin
                // in_ready is low here, so no new input can compete
                main_valid_d   = 1'b1;
                main_imm_d     = skid_imm_q;
                main_fmt_d     = skid_fmt_q;
                main_illegal_d = skid_illegal_q;
                main_tag_d     = skid_tag_q;
                skid_valid_d   = 1'b0;
            end else begin
                main_valid_d = in_fire;
                if (in_fire) begin
                    main_imm_d     = dec_imm;
                    main_fmt_d     = dec_fmt;
                    main_illegal_d = dec_illegal;
                    main_tag_d     = in_tag;
                end
            end
        end else if (in_fire) begin
            skid_valid_d   = 1'b1;
            skid_imm_d     = dec_imm;
            skid_fmt_d     = dec_fmt;
            skid_illegal_d = dec_illegal;
            skid_tag_d     = in_tag;
        end
    end

    // State registers; data cleared on reset so outputs read zero while held
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_q   <= 1'b0;
            main_imm_q     <= '0;
            main_fmt_q     <= FmtNone;
            main_illegal_q <= 1'b0;
            main_tag_q     <= '0;
            skid_valid_q   <= 1'b0;
            skid_imm_q     <= '0;
            skid_fmt_q     <= FmtNone;
            skid_illegal_q <= 1'b0;
            skid_tag_q     <= '0;
        end else begin
            main_valid_q   <= main_valid_d;
            main_imm_q     <= main_imm_d;
            main_fmt_q     <= main_fmt_d;
            main_illegal_q <= main_illegal_d;
            main_tag_q     <= main_tag_d;
            skid_valid_q   <= skid_valid_d;
            skid_imm_q     <= skid_imm_d;
            skid_fmt_q     <= skid_fmt_d;
            skid_illegal_q <= skid_illegal_d;
            skid_tag_q     <= skid_tag_d;
        end
    end

    // Outputs come directly from registers
    always_comb begin
        in_ready  = !skid_valid_q;
        out_valid = main_valid_q;
        imm       = main_imm_q;
        fmt       = main_fmt_q;
        illegal   = main_illegal_q;
        out_tag   = main_tag_q;
    end

endmodule
